// File: rtl/vec_bist_pkg.sv
// Shared types and width helpers for the vector BIST engine.
package vec_bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SETTLE,
      ST_CHECK,
      ST_HOLD,
      ST_DONE
   } state_t;

   // Width of a row index; a single-row table still needs one address bit.
   function automatic int addr_w(input int rows);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

   function automatic int cnt_w(input int rows);
      return $clog2(rows + 1);
   endfunction

endpackage

// File: rtl/vector_rom.sv
// Synchronous truth-table ROM: one {inputs, expected} row per address, 1-cycle read latency.
module vector_rom
   import vec_bist_pkg::*;
#(
   parameter int                      ROWS     = 8,
   parameter int                      WIDTH    = 4,
   parameter string                   VEC_FILE = "vectors.txt",
   parameter logic [ROWS*WIDTH-1:0]   VEC_INIT = '0,
   localparam int                     ADDR_W   = addr_w(ROWS)
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   output logic [WIDTH-1:0]  data
);

   logic [WIDTH-1:0] mem [ROWS];

   // Table packed into VEC_INIT (row i at bits i*WIDTH).
   for (genvar i = 0; i < ROWS; i++) begin : g_row
      assign mem[i] = VEC_INIT[i*WIDTH +: WIDTH];
   end

   always_ff @(posedge clk) begin
      data <= mem[addr];
   end

endmodule

// File: rtl/vec_bist.sv
// Vector BIST engine: walks the truth table, applies each row to the UUT, checks after a settle interval.
module vec_bist
   import vec_bist_pkg::*;
#(
   parameter int    ROWS          = 8,
   parameter int    INPUTS        = 3,
   parameter int    OUTPUTS       = 1,
   parameter int    SETTLE_CYCLES = 4,
   parameter int    HOLD_CYCLES   = 4,
   parameter string VEC_FILE      = "vectors.txt",
   parameter logic [ROWS*(INPUTS+OUTPUTS)-1:0] VEC_INIT = '0,
   localparam int   ADDR_W        = addr_w(ROWS),
   localparam int   CNT_W         = cnt_w(ROWS)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   output logic [INPUTS-1:0]  uut_in,
   input  logic [OUTPUTS-1:0] uut_out,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [CNT_W-1:0]   mm_count,
   output logic [ADDR_W-1:0]  first_fail_idx,
   output logic               first_fail_valid
);

   localparam int TMR_MAX = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
   localparam int TW      = $clog2(TMR_MAX + 1);
   localparam logic [TW-1:0]     SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0]     HOLD_LOAD   = TW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
   localparam logic [ADDR_W-1:0] LAST_ROW    = ADDR_W'(ROWS - 1);
   localparam logic [CNT_W-1:0]  MM_MAX      = CNT_W'(ROWS);

   state_t               state, state_d;
   logic [ADDR_W-1:0]    row, row_d;
   logic [TW-1:0]        tmr, tmr_d;
   logic [OUTPUTS-1:0]   exp_q;
   logic [INPUTS+OUTPUTS-1:0] rom_data;
   logic                 clear_run;
   logic                 advance;

   // The ROM is addressed with the next row so its data is ready during FETCH.
   vector_rom #(
      .ROWS     (ROWS),
      .WIDTH    (INPUTS + OUTPUTS),
      .VEC_FILE (VEC_FILE),
      .VEC_INIT (VEC_INIT)
   ) u_rom (
      .clk  (clk),
      .addr (row_d),
      .data (rom_data)
   );

   always_comb begin
      state_d   = state;
      row_d     = row;
      tmr_d     = tmr;
      clear_run = 1'b0;
      advance   = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d   = ST_FETCH;
               row_d     = '0;
               clear_run = 1'b1;
            end
         end
         ST_FETCH: begin
            state_d = ST_SETTLE;
            tmr_d   = SETTLE_LOAD;
         end
         ST_SETTLE: begin
            if (tmr == '0) state_d = ST_CHECK;
            else           tmr_d   = tmr - 1'b1;
         end
         ST_CHECK: begin
            if (HOLD_CYCLES > 0) begin
               state_d = ST_HOLD;
               tmr_d   = HOLD_LOAD;
            end else begin
               advance = 1'b1;
            end
         end
         ST_HOLD: begin
            if (tmr == '0) advance = 1'b1;
            else           tmr_d   = tmr - 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      if (advance) begin
         if (row == LAST_ROW) begin
            state_d = ST_DONE;
         end else begin
            state_d = ST_FETCH;
            row_d   = row + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= ST_IDLE;
         row              <= '0;
         tmr              <= '0;
         uut_in           <= '0;
         exp_q            <= '0;
         mm_count         <= '0;
         first_fail_idx   <= '0;
         first_fail_valid <= 1'b0;
      end else begin
         state <= state_d;
         row   <= row_d;
         tmr   <= tmr_d;
         if (state == ST_FETCH) {uut_in, exp_q} <= rom_data;
         if (clear_run) begin
            mm_count         <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
         end else if (state == ST_CHECK && uut_out != exp_q) begin
            if (mm_count != MM_MAX) mm_count <= mm_count + 1'b1;
            if (!first_fail_valid) begin
               first_fail_idx   <= row;
               first_fail_valid <= 1'b1;
            end
         end
      end
   end

   assign busy = (state == ST_FETCH) || (state == ST_SETTLE) ||
                 (state == ST_CHECK) || (state == ST_HOLD);
   assign done = (state == ST_DONE);
   assign pass = done && (mm_count == '0);

endmodule
